bus_drive_arbiter: RTL

Round-robin arbiter that shares one N-bit tri-state bus between NREQ requesters. Each requester drives the bus through its own bufferNbits instance. This block generates the one-hot buffer enables and guarantees that at most one buffer drives at any time. A turnaround cycle with no driver separates successive owners, so the bus never sees contention.

---
 rtl/bus_drive_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/bus_drive_arbiter.sv
// Round-robin owner selection for a shared tri-state bus, with an idle turnaround between owners.
// Optional forced release after HOLD_MAX drive cycles when BUS_ARB_TIMEOUT_EN is defined.
module bus_drive_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         buf_en,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic                    timeout
);

  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || HOLD_MAX < 1) begin : g_bad_cfg
    $error("bus_drive_arbiter: NREQ must be 2..8 and HOLD_MAX must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_DRIVE,
    S_RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] buf_en_q, buf_en_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   pick;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [HW-1:0]   hold_q, hold_d;
  logic            timeout_q, timeout_d;
`endif

  // First set request at or above start, wrapping modulo NREQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   start);
    logic [IW-1:0] win;
    logic          found;
    int unsigned   idx;
    win   = start;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(start) + i) % NREQ;
      if (!found && r[IW'(idx)]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] o);
    return (o == IW'(NREQ - 1)) ? '0 : o + 1'b1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      buf_en_q  <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      buf_en_q  <= buf_en_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    buf_en_d  = buf_en_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    // In RELEASE, ptr_q already holds the advanced pointer.
    pick      = rr_pick(req, ptr_q);

    case (state_q)
      S_IDLE, S_RELEASE: begin
        grant_d  = '0;
        buf_en_d = '0;
        state_d  = S_IDLE;
        if (|req) begin
          owner_d = pick;
          grant_d = onehot(pick);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (req[owner_q]) begin
          state_d  = S_DRIVE;
          buf_en_d = grant_q;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_d   = '0;
`endif
        end else begin
          state_d = S_RELEASE;
          grant_d = '0;
          ptr_d   = next_ptr(owner_q);
        end
      end
      S_DRIVE: begin
`ifdef BUS_ARB_TIMEOUT_EN
        hold_d = hold_q + 1'b1;
`endif
        if (!req[owner_q]) begin
          state_d  = S_RELEASE;
          grant_d  = '0;
          buf_en_d = '0;
          ptr_d    = next_ptr(owner_q);
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_q == HW'(HOLD_MAX - 1)) begin
          state_d   = S_RELEASE;
          grant_d   = '0;
          buf_en_d  = '0;
          ptr_d     = next_ptr(owner_q);
          timeout_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d  = S_IDLE;
        grant_d  = '0;
        buf_en_d = '0;
      end
    endcase

    busy_d = |buf_en_d;
  end

  always_comb begin
    grant   = grant_q;
    buf_en  = buf_en_q;
    owner   = owner_q;
    busy    = busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
    timeout = timeout_q;
`else
    timeout = 1'b0;
`endif
  end

  a_drive_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(buf_en_q) && ((buf_en_q & ~grant_q) == '0));

endmodule
